// File: rtl/alu_station.sv
// alu_station: single-entry reservation station with an integer ALU.
// Operands arrive either as values (tag 0) or as producer tags. They are
// resolved by snooping the four unit write-back buses. The result is
// broadcast under UNIT_TAG.
// Optional macro ALU_STATION_BYPASS_EN lets operands resolved by a broadcast
// in the current cycle feed the ALU directly, saving one cycle.
module alu_station #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 3,
  parameter int UNIT_TAG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              en_disp,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] datax,
  input  logic [DATA_W-1:0] datay,
  input  logic [TAG_W-1:0]  tagx,
  input  logic [TAG_W-1:0]  tagy,
  input  logic [4:0]        rd_addr,
  output logic              busy,
  input  logic              en_wb0,
  input  logic              en_wb1,
  input  logic              en_wb2,
  input  logic              en_wb3,
  input  logic [DATA_W-1:0] wb_data0,
  input  logic [DATA_W-1:0] wb_data1,
  input  logic [DATA_W-1:0] wb_data2,
  input  logic [DATA_W-1:0] wb_data3,
  output logic              en_out,
  output logic [4:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  tag_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  localparam logic [1:0] SELF_IDX = 2'(UNIT_TAG - 1);
  localparam bit SELF_ON_BUS = (UNIT_TAG >= 1) && (UNIT_TAG <= 4);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        addr_q, addr_d;
  opnd_t             x_q, x_d, y_q, y_d;
  logic              enOut_q, enOut_d;
  logic [4:0]        outAddr_q, outAddr_d;
  logic [DATA_W-1:0] outData_q, outData_d;

  logic [3:0]             busEn;
  logic [3:0][DATA_W-1:0] busData;
  opnd_t                  dispX, dispY, snoopX, snoopY;

  // A pending tag k resolves when bus k-1 is valid; tags above 4 never resolve.
  function automatic opnd_t snoop(input opnd_t src, input logic [3:0] en,
                                  input logic [3:0][DATA_W-1:0] data);
    opnd_t res;
    logic [TAG_W-1:0] tagM1;
    res   = src;
    tagM1 = src.tag - TAG_W'(1);
    if (src.tag != '0 && src.tag <= TAG_W'(4)) begin
      if (en[tagM1[1:0]]) begin
        res.tag = '0;
        res.val = data[tagM1[1:0]];
      end
    end
    return res;
  endfunction

  // Wrap-around integer ALU; shifts use only the low five bits of y.
  function automatic logic [DATA_W-1:0] aluCompute(input logic [3:0] o,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic [4:0]        sh;
    sh = b[4:0];
    case (o)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = $signed(a) >>> sh;
      4'd8:    r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    r = {{(DATA_W-1){1'b0}}, (a < b)};
      4'd10:   r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Gather the write-back buses; our own result is folded into its slot so a
  // dependent op dispatched in the result cycle picks it up immediately.
  always_comb begin
    busEn   = {en_wb3, en_wb2, en_wb1, en_wb0};
    busData = {wb_data3, wb_data2, wb_data1, wb_data0};
    if (SELF_ON_BUS && enOut_q) begin
      busEn[SELF_IDX]   = 1'b1;
      busData[SELF_IDX] = outData_q;
    end
  end

  // Resolve incoming dispatch operands and pending stored operands against the buses.
  always_comb begin
    dispX  = snoop({tagx, datax}, busEn, busData);
    dispY  = snoop({tagy, datay}, busEn, busData);
    snoopX = snoop(x_q, busEn, busData);
    snoopY = snoop(y_q, busEn, busData);
  end

  // Next-state logic: capture on dispatch, wait for both tags to clear, then compute.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    x_d       = x_q;
    y_d       = y_q;
    enOut_d   = 1'b0;
    outAddr_d = outAddr_q;
    outData_d = outData_q;
    case (state_q)
      S_IDLE: begin
        if (en_disp) begin
          op_d   = op;
          addr_d = rd_addr;
          x_d    = dispX;
          y_d    = dispY;
`ifdef ALU_STATION_BYPASS_EN
          if (dispX.tag == '0 && dispY.tag == '0) begin
            enOut_d   = 1'b1;
            outAddr_d = rd_addr;
            outData_d = aluCompute(op, dispX.val, dispY.val);
          end else begin
            state_d = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        x_d = snoopX;
        y_d = snoopY;
`ifdef ALU_STATION_BYPASS_EN
        if (snoopX.tag == '0 && snoopY.tag == '0) begin
          enOut_d   = 1'b1;
          outAddr_d = addr_q;
          outData_d = aluCompute(op_q, snoopX.val, snoopY.val);
          state_d   = S_IDLE;
        end
`else
        if (x_q.tag == '0 && y_q.tag == '0) begin
          enOut_d   = 1'b1;
          outAddr_d = addr_q;
          outData_d = aluCompute(op_q, x_q.val, y_q.val);
          state_d   = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any held op, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      enOut_q   <= 1'b0;
      outAddr_q <= '0;
      outData_q <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      enOut_q   <= enOut_d;
      outAddr_q <= outAddr_d;
      outData_q <= outData_d;
    end
  end

  assign busy     = (state_q == S_WAIT);
  assign en_out   = enOut_q;
  assign out_addr = outAddr_q;
  assign out_data = outData_q;
  assign tag_out  = TAG_W'(UNIT_TAG);

endmodule
